pipe_scroller: RTL and testbench

- Generates and scrolls the pipe obstacle field for the 16x16 LED game.
- Sits directly upstream of the game/collision stage: drives its obstacle-field input and produces a pass pulse for the score chain.
- Pipe gaps come from an internal LFSR.
- Pipe spacing and scroll rate are set by a parameter and an external enable tick.

---
 rtl/pipe_scroller.sv | 82 ++++++++
 tb/tb_pipe_scroller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Pipe obstacle generator and scroller for the 16x16 LED game.
// New pipes enter at the right edge with LFSR-chosen gaps; pass pulses on leaving the bird column.
module pipe_scroller #(
    parameter int          ROWS     = 16,
    parameter int          COLS     = 16,
    parameter int          GAP      = 4,
    parameter int          SPACING  = 6,
    parameter int          BIRD_COL = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           freeze,
    output logic [ROWS-1:0][COLS-1:0]      field,
    output logic                           pass,
    output logic [7:0]                     pipe_count
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam int          GAP_MOD  = ROWS - GAP - 1;
    localparam int          SPC_W    = (SPACING > 2) ? $clog2(SPACING) : 1;
    localparam logic [SPC_W-1:0] SPC_LAST = SPC_W'(SPACING - 1);

    logic [ROWS-1:0][COLS-1:0] r_field;
    logic [COLS-1:0]           r_mask;
    logic [SPC_W-1:0]          r_spc;
    logic [15:0]               r_lfsr;
    logic                      r_pass;
    logic [7:0]                r_cnt;

    logic                      w_step;
    logic                      w_pipe;
    logic [15:0]               w_lfsr_nxt;
    logic [ROWS-1:0]           w_new_col;
    int                        w_gap_top;

    assign w_step     = enable & ~freeze;
    assign w_pipe     = (r_spc == '0);
    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);

    // Gap is kept off rows 0 and ROWS-1 so both pipe segments always show.
    always_comb begin
        w_gap_top = 1 + (int'(r_lfsr[3:0]) % GAP_MOD);
        w_new_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_new_col[r] = w_pipe && !(r >= w_gap_top && r < w_gap_top + GAP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_field <= '0;
            r_mask  <= '0;
            r_spc   <= '0;
            r_lfsr  <= SEED_EFF;
            r_pass  <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_pass <= w_step & r_mask[BIRD_COL];
            if (w_step) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_field[r] <= {w_new_col[r], r_field[r][COLS-1:1]};
                end
                r_mask <= {w_pipe, r_mask[COLS-1:1]};
                r_spc  <= (r_spc == SPC_LAST) ? '0 : r_spc + 1'b1;
                if (w_pipe) begin
                    r_lfsr <= w_lfsr_nxt;
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign field      = r_field;
    assign pass       = r_pass;
    assign pipe_count = r_cnt;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller.
// Reference model tracks pipes as (column, gap_top) records.
module tb_pipe_scroller;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int GAP = 4;
    localparam int SPACING = 6;
    localparam int BIRD_COL = 4;

    typedef logic [ROWS-1:0][COLS-1:0] fld_t;
    typedef struct {
        int x;
        int gt;
    } pipe_t;

    logic clk;
    logic reset;
    logic enable;
    logic freeze;
    fld_t field;
    logic pass;
    logic [7:0] pipe_count;

    int n_vec;
    int n_err;

    pipe_t m_q[$];
    int m_steps;
    int m_cnt;
    logic [15:0] m_lfsr;
    logic m_pass;

    pipe_scroller dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .freeze(freeze),
        .field(field),
        .pass(pass),
        .pipe_count(pipe_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic m_reset();
        m_q.delete();
        m_steps = 0;
        m_cnt = 0;
        m_lfsr = 16'hACE1;
        m_pass = 1'b0;
    endtask

    task automatic m_step();
        pipe_t p;
        pipe_t nq[$];
        m_pass = 1'b0;
        foreach (m_q[i]) begin
            if (m_q[i].x == BIRD_COL) m_pass = 1'b1;
            p = m_q[i];
            p.x = p.x - 1;
            if (p.x >= 0) nq.push_back(p);
        end
        if (m_steps % SPACING == 0) begin
            p.x = COLS - 1;
            p.gt = 1 + (int'(m_lfsr[3:0]) % (ROWS - GAP - 1));
            nq.push_back(p);
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            if (m_cnt < 255) m_cnt++;
        end
        m_q = nq;
        m_steps++;
    endtask

    function automatic fld_t m_field();
        fld_t e;
        e = '0;
        foreach (m_q[i]) begin
            for (int r = 0; r < ROWS; r++) begin
                if (r < m_q[i].gt || r >= m_q[i].gt + GAP) e[r][m_q[i].x] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [ROWS-1:0] col_of(fld_t f, int c);
        logic [ROWS-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r] = f[r][c];
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        freeze = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic pulse();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        if (!freeze) m_step();
        else m_pass = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (100) @(negedge clk);
        n_vec++;
        if (field !== '0) begin
            n_err++;
            $display("FAIL reset_field: got %h exp 0", field);
        end
        n_vec++;
        if (pass !== 1'b0 || pipe_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_outs: got pass=%b cnt=%0d exp 0/0", pass, pipe_count);
        end
    endtask

    task automatic test_first_pipe();
        logic [ROWS-1:0] c15;
        pulse();
        c15 = col_of(field, 15);
        n_vec++;
        if (c15 !== 16'hFFC3) begin
            n_err++;
            $display("FAIL first_col15: got %h exp ffc3", c15);
        end
        n_vec++;
        if (field !== m_field()) begin
            n_err++;
            $display("FAIL first_field: got %h exp %h", field, m_field());
        end
        n_vec++;
        if (pipe_count !== 8'd1) begin
            n_err++;
            $display("FAIL first_cnt: got %0d exp 1", pipe_count);
        end
    endtask

    task automatic test_second_pipe();
        repeat (6) pulse();
        n_vec++;
        if (col_of(field, 9) !== 16'hFFC3 || col_of(field, 15) !== 16'hFFE1) begin
            n_err++;
            $display("FAIL second_cols: got c9=%h c15=%h exp ffc3/ffe1",
                     col_of(field, 9), col_of(field, 15));
        end
        n_vec++;
        if (field !== m_field() || pipe_count !== 8'd2) begin
            n_err++;
            $display("FAIL second_field: got %h cnt=%0d exp %h cnt=2",
                     field, pipe_count, m_field());
        end
    endtask

    task automatic test_pass();
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            pulse();
            n_vec++;
            if (pass !== (k == 13) || pass !== m_pass) begin
                n_err++;
                $display("FAIL pass_step%0d: got %b exp %b", k, pass, k == 13);
            end
        end
        @(negedge clk);
        n_vec++;
        if (pass !== 1'b0) begin
            n_err++;
            $display("FAIL pass_width: got %b exp 0", pass);
        end
    endtask

    task automatic test_freeze();
        fld_t held;
        logic [7:0] held_cnt;
        do_reset();
        repeat (5) pulse();
        held = field;
        held_cnt = pipe_count;
        freeze = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pulse();
            n_vec++;
            if (field !== held || pipe_count !== held_cnt || pass !== 1'b0) begin
                n_err++;
                $display("FAIL freeze_hold%0d: got cnt=%0d pass=%b exp cnt=%0d pass=0",
                         k, pipe_count, pass, held_cnt);
            end
        end
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        freeze = 1'b0;
        n_vec++;
        if (field !== held) begin
            n_err++;
            $display("FAIL freeze_wins: got %h exp %h", field, held);
        end
        pulse();
        n_vec++;
        if (field !== m_field() || pipe_count !== 8'(m_cnt)) begin
            n_err++;
            $display("FAIL freeze_resume: got %h exp %h", field, m_field());
        end
    endtask

    task automatic test_async_reset();
        repeat (8) pulse();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_vec++;
        if (field !== '0 || pass !== 1'b0 || pipe_count !== 8'd0) begin
            n_err++;
            $display("FAIL async_clear: got cnt=%0d pass=%b field=%h exp 0", pipe_count, pass, field);
        end
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        pulse();
        n_vec++;
        if (col_of(field, 15) !== 16'hFFC3 || field !== m_field() || pipe_count !== 8'd1) begin
            n_err++;
            $display("FAIL async_repeat: got %h cnt=%0d exp %h cnt=1", field, pipe_count, m_field());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k >= 1000 && k < 2700) begin
                enable = 1'b1;
                freeze = 1'b0;
            end else begin
                enable = ($urandom_range(0, 2) != 0);
                freeze = ($urandom_range(0, 5) == 0);
            end
            @(posedge clk);
            if (enable && !freeze) m_step();
            else m_pass = 1'b0;
            #1;
            n_vec++;
            if (field !== m_field() || pass !== m_pass || pipe_count !== 8'(m_cnt)) begin
                n_err++;
                $display("FAIL random_%0d: got cnt=%0d pass=%b field=%h exp cnt=%0d pass=%b field=%h",
                         k, pipe_count, pass, field, m_cnt, m_pass, m_field());
            end
        end
        enable = 1'b0;
        freeze = 1'b0;
        n_vec++;
        if (pipe_count !== 8'd255) begin
            n_err++;
            $display("FAIL saturate: got %0d exp 255", pipe_count);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        enable = 1'b0;
        freeze = 1'b0;
        m_reset();
        test_reset();
        test_first_pipe();
        test_second_pipe();
        test_pass();
        test_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
